serial_bus_master: RTL and testbench
====================================

SERIAL_BUS_MASTER -- requirements
Module: serial_bus_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1000000, SHALL set the number of idle cycles between frame bytes after which a partial frame is abandoned.
REQ-002 clk  input  1  single system clock; all state changes on its rising edge.
REQ-003 reset  input  1  SHALL be synchronous and active-high; it is sampled only on the rising edge of clk.
REQ-004 rx_valid  input  1  one-cycle strobe: rx_data holds a received byte.
REQ-005 rx_data  input  8  received byte from the UART receiver.
REQ-006 tx_data  output  8  byte offered to the UART sender.
REQ-007 tx_valid  output  1  tx_data is valid; held until accepted.
REQ-008 tx_ready  input  1  sender accepts tx_data in a cycle where tx_valid and tx_ready are both high.
REQ-009 rd  output  1  peripheral bus read strobe.
REQ-010 wr  output  1  peripheral bus write strobe.
REQ-011 addr  output  32  peripheral bus address.
REQ-012 wdata  output  32  peripheral bus write data.
REQ-013 rdata  input  32  peripheral bus read data, combinational from addr while rd is high.
REQ-014 busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The block SHALL be the bus initiator: it decodes command frames from the byte stream, issues one peripheral access per frame, and returns a response byte stream.
REQ-016 Frame format: command byte, then 4 address bytes MSB first; a write adds 4 data bytes MSB first.
- 0x52 ('R') = read.
- 0x57 ('W') = write.
REQ-017 States SHALL be IDLE, ADDR, DATA, BUS, RESP.
REQ-018 State transitions:
- IDLE: accept 0x52/0x57 -> ADDR; any other byte -> RESP with the single byte 0x3F ('?').
- ADDR: after the 4th address byte -> DATA for a write; -> BUS for a read.
- DATA: after the 4th data byte -> BUS.
- BUS: lasts exactly one cycle, then -> RESP.
- RESP: after the last response byte is accepted -> IDLE.
REQ-019 An rx_valid pulse in BUS or RESP SHALL be dropped without any effect.
REQ-020 If the assembled address has addr[1:0] != 2'b00, BUS SHALL issue no strobe and the response SHALL be the single byte 0x3F.
REQ-021 rd or wr SHALL be high for exactly the one BUS cycle, which is the cycle immediately after the edge that accepted the final frame byte; rd and wr are never both high.
REQ-022 addr and wdata SHALL be stable during the BUS cycle and hold their values afterwards until the next frame loads them.
REQ-023 On a read, rdata SHALL be captured at the edge that ends the BUS cycle.
REQ-024 Response contents:
- Read: 4 bytes of captured rdata, MSB first.
- Write: the single byte 0x4B ('K').
REQ-025 tx_valid SHALL rise in the cycle after BUS, or after the offending byte for the IDLE error case.
REQ-026 tx_data SHALL stay constant while tx_valid is high and tx_ready is low.
REQ-027 The next response byte SHALL be presented in the cycle after the previous byte is accepted; with tx_ready held high, a read response occupies 4 consecutive cycles.
REQ-028 Inter-byte timeout in ADDR or DATA:
- A 32-bit counter clears on every accepted byte and increments on every other cycle.
- When it reaches TIMEOUT_CYCLES-1, the state SHALL return to IDLE with no bus access and no response.
REQ-029 busy SHALL fall in the cycle after the final response byte is accepted.

Reset
REQ-030 While reset is sampled high:
- state = IDLE; byte counters and timeout counter = 0.
- rd = 0, wr = 0, addr = 32'h0, wdata = 32'h0.
- tx_valid = 0, tx_data = 8'h00, busy = 0.
REQ-031 A reset mid-frame or mid-response SHALL discard the partial frame or response; no strobe or response byte is produced afterwards for it.

Verification
REQ-032 Write: bytes 57 40 00 00 0C 00 00 00 A5, tx_ready=1 -> one wr cycle with addr=32'h4000000C, wdata=32'h000000A5; then tx_data=8'h4B for one cycle; busy drops.
REQ-033 Read: bytes 52 40 00 00 10 with rdata=32'h0000005A when addr=32'h40000010 -> one rd cycle; then tx bytes 00 00 00 5A on 4 consecutive cycles.
REQ-034 Backpressure: read response with tx_ready low for 5 cycles per byte -> each byte held stable and sent exactly once; rx_valid pulses during RESP ignored.
REQ-035 Errors:
- Byte 0x41 in IDLE -> response 3F, no strobe.
- Write to addr 32'h40000002 -> response 3F, wr never high.
REQ-036 Timeout: TIMEOUT_CYCLES=16; send 52 40 then idle 20 cycles -> return to IDLE, no rd, no tx; a following full read frame executes normally.
REQ-037 Reset after 3 address bytes, then a full write frame -> only the second frame's wr and 4B response appear.

Source files
------------

// File: rtl/serial_bus_master_if.sv
// Byte-stream and peripheral-bus signals of the serial bus master.
// The master modport is the bus initiator's view; the slave modport is the environment's view.
interface serial_bus_master_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (
        input  rx_valid, rx_data, tx_ready, rdata,
        output tx_data, tx_valid, rd, wr, addr, wdata
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, rdata,
        input  tx_data, tx_valid, rd, wr, addr, wdata
    );
endinterface

// File: rtl/serial_bus_master.sv
// Decodes 'R'/'W' command frames from a UART byte stream, performs one peripheral
// access per frame and streams the response bytes back out.
module serial_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_bus_master_if.master  bus,
    output logic                 busy
);
    typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_t;

    localparam logic [7:0]  CMD_RD       = 8'h52;
    localparam logic [7:0]  CMD_WR       = 8'h57;
    localparam logic [7:0]  RSP_ERR      = 8'h3F;
    localparam logic [7:0]  RSP_OK       = 8'h4B;
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      state_q, state_d;
    logic        is_wr_q, is_wr_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] addr_sh_q, addr_sh_d;
    logic [23:0] data_sh_q, data_sh_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [23:0] resp_sh_q, resp_sh_d;
    logic [2:0]  resp_left_q, resp_left_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;

    logic [31:0] next_addr;
    logic [31:0] next_data;

    // Frame bytes are assembled in shadow registers so that addr/wdata only change
    // when a complete frame is accepted.
    assign next_addr = {addr_sh_q[23:0], bus.rx_data};
    assign next_data = {data_sh_q, bus.rx_data};

    always_comb begin
        state_d     = state_q;
        is_wr_d     = is_wr_q;
        byte_cnt_d  = byte_cnt_q;
        timer_d     = '0;
        addr_sh_d   = addr_sh_q;
        data_sh_d   = data_sh_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        resp_sh_d   = resp_sh_q;
        resp_left_d = resp_left_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;

        case (state_q)
            IDLE: begin
                byte_cnt_d = '0;
                if (bus.rx_valid) begin
                    if (bus.rx_data == CMD_RD || bus.rx_data == CMD_WR) begin
                        is_wr_d = (bus.rx_data == CMD_WR);
                        state_d = ADDR;
                    end else begin
                        state_d     = RESP;
                        tx_valid_d  = 1'b1;
                        tx_data_d   = RSP_ERR;
                        resp_left_d = 3'd1;
                    end
                end
            end
            ADDR: begin
                if (bus.rx_valid) begin
                    addr_sh_d  = next_addr;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (is_wr_q) begin
                            state_d = DATA;
                        end else begin
                            state_d = BUS;
                            addr_d  = next_addr;
                            rd_d    = (next_addr[1:0] == 2'b00);
                        end
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            DATA: begin
                if (bus.rx_valid) begin
                    data_sh_d  = next_data[23:0];
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        state_d = BUS;
                        addr_d  = addr_sh_q;
                        wdata_d = next_data;
                        wr_d    = (addr_sh_q[1:0] == 2'b00);
                    end
                end else if (timer_q == TIMEOUT_LAST) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            BUS: begin
                // No strobe in this cycle means the address was misaligned.
                state_d    = RESP;
                tx_valid_d = 1'b1;
                if (rd_q) begin
                    resp_sh_d   = bus.rdata[23:0];
                    tx_data_d   = bus.rdata[31:24];
                    resp_left_d = 3'd4;
                end else if (wr_q) begin
                    tx_data_d   = RSP_OK;
                    resp_left_d = 3'd1;
                end else begin
                    tx_data_d   = RSP_ERR;
                    resp_left_d = 3'd1;
                end
            end
            RESP: begin
                if (tx_valid_q && bus.tx_ready) begin
                    if (resp_left_q == 3'd1) begin
                        tx_valid_d  = 1'b0;
                        resp_left_d = '0;
                        state_d     = IDLE;
                    end else begin
                        resp_left_d = resp_left_q - 3'd1;
                        tx_data_d   = resp_sh_q[23:16];
                        resp_sh_d   = {resp_sh_q[15:0], 8'h00};
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            is_wr_q     <= 1'b0;
            byte_cnt_q  <= '0;
            timer_q     <= '0;
            addr_sh_q   <= '0;
            data_sh_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            resp_sh_q   <= '0;
            resp_left_q <= '0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            is_wr_q     <= is_wr_d;
            byte_cnt_q  <= byte_cnt_d;
            timer_q     <= timer_d;
            addr_sh_q   <= addr_sh_d;
            data_sh_q   <= data_sh_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            resp_sh_q   <= resp_sh_d;
            resp_left_q <= resp_left_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.rd       = rd_q;
    assign bus.wr       = wr_q;
    assign bus.addr     = addr_q;
    assign bus.wdata    = wdata_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.tx_valid = tx_valid_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_serial_bus_master.sv
// Directed bench for serial_bus_master: a table of whole frames with hand-computed
// strobe/response expectations, plus sequences for backpressure, timeout and reset.
module tb_serial_bus_master;
    logic clk = 1'b0;
    logic reset;
    logic busy;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    serial_bus_master_if ifc();

    serial_bus_master #(.TIMEOUT_CYCLES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.master),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Peripheral model: one fixed register, everything else returns an address pattern.
    function automatic logic [31:0] periph_read(input logic [31:0] a);
        return (a == 32'h40000010) ? 32'h0000005A : (a ^ 32'hDEADBEEF);
    endfunction
    assign ifc.rdata = ifc.rd ? periph_read(ifc.addr) : 32'h0;

    int          strobe_cnt = 0;
    int          strobe_cyc = -1;
    int          strobe_kind = 0;
    int          both_err = 0;
    int          stab_err = 0;
    int          busy_fall_cyc = -1;
    logic [31:0] strobe_addr = '0;
    logic [31:0] strobe_wdata = '0;
    logic [7:0]  tx_q[$];
    int          txc_q[$];
    logic        prev_hold = 1'b0;
    logic        prev_busy = 1'b0;
    logic [7:0]  prev_data = '0;

    // Observes the DUT on the falling edge, half a cycle away from every input change.
    always @(negedge clk) begin
        if (ifc.rd && ifc.wr) both_err++;
        if (ifc.rd || ifc.wr) begin
            strobe_cnt++;
            strobe_cyc   = cyc;
            strobe_kind  = ifc.rd ? 1 : 2;
            strobe_addr  = ifc.addr;
            strobe_wdata = ifc.wdata;
        end
        if (ifc.tx_valid && ifc.tx_ready) begin
            tx_q.push_back(ifc.tx_data);
            txc_q.push_back(cyc);
        end
        if (prev_hold && (!ifc.tx_valid || ifc.tx_data != prev_data)) stab_err++;
        prev_hold = ifc.tx_valid && !ifc.tx_ready && !reset;
        prev_data = ifc.tx_data;
        if (prev_busy && !busy) busy_fall_cyc = cyc;
        prev_busy = busy;
    end

    typedef struct {
        logic [71:0] frame;
        int          nbytes;
        int          kind;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        int          nresp;
        logic [31:0] eresp;
        int          first_off;
    } vec_t;

    vec_t vecs[7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic send_bytes(input logic [71:0] frame, input int n, output int accept_cyc);
        accept_cyc = cyc;
        for (int i = 0; i < n; i++) begin
            ifc.rx_valid = 1'b1;
            ifc.rx_data  = frame[71-8*i -: 8];
            accept_cyc   = cyc + 1;
            tick();
        end
        ifc.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        while (busy && k < 60) begin
            tick();
            k++;
        end
        checkOutput({name, " settles"}, {31'b0, busy}, 32'h0);
    endtask

    task automatic wait_tx_valid(input string name);
        int k = 0;
        while (!ifc.tx_valid && k < 30) begin
            tick();
            k++;
        end
        checkOutput({name, " tx_valid rises"}, {31'b0, ifc.tx_valid}, 32'h1);
    endtask

    task automatic check_reset_state(input string name);
        checkOutput({name, " rd"}, {31'b0, ifc.rd}, 32'h0);
        checkOutput({name, " wr"}, {31'b0, ifc.wr}, 32'h0);
        checkOutput({name, " addr"}, ifc.addr, 32'h0);
        checkOutput({name, " wdata"}, ifc.wdata, 32'h0);
        checkOutput({name, " tx_valid"}, {31'b0, ifc.tx_valid}, 32'h0);
        checkOutput({name, " tx_data"}, {24'b0, ifc.tx_data}, 32'h0);
        checkOutput({name, " busy"}, {31'b0, busy}, 32'h0);
    endtask

    task automatic applyStimulus(input int idx);
        vec_t  v;
        int    a, first, s0, t0;
        string nm;
        v  = vecs[idx];
        nm = $sformatf("v%0d", idx);
        s0 = strobe_cnt;
        t0 = tx_q.size();
        ifc.tx_ready = 1'b1;
        send_bytes(v.frame, v.nbytes, a);
        wait_idle(nm);
        tick();
        tick();
        first = a + v.first_off;
        checkOutput({nm, " strobes"}, strobe_cnt - s0, (v.kind != 0) ? 1 : 0);
        if (v.kind != 0) begin
            checkOutput({nm, " strobe kind"}, strobe_kind, v.kind);
            checkOutput({nm, " strobe cycle"}, strobe_cyc, a);
            checkOutput({nm, " strobe addr"}, strobe_addr, v.eaddr);
            checkOutput({nm, " addr held"}, ifc.addr, v.eaddr);
            if (v.kind == 2) checkOutput({nm, " strobe wdata"}, strobe_wdata, v.ewdata);
        end
        checkOutput({nm, " tx count"}, tx_q.size() - t0, v.nresp);
        for (int j = 0; j < v.nresp && t0 + j < tx_q.size(); j++) begin
            checkOutput($sformatf("%s tx byte %0d", nm, j), {24'b0, tx_q[t0+j]}, {24'b0, v.eresp[31-8*j -: 8]});
            checkOutput($sformatf("%s tx cycle %0d", nm, j), txc_q[t0+j], first + j);
        end
        checkOutput({nm, " busy fall cycle"}, busy_fall_cyc, first + v.nresp);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int a, s0, t0;
        logic [31:0] bp_exp;

        vecs[0] = '{72'h57_40_00_00_0C_00_00_00_A5, 9, 2, 32'h4000000C, 32'h000000A5, 1, 32'h4B000000, 1};
        vecs[1] = '{72'h52_40_00_00_10_00_00_00_00, 5, 1, 32'h40000010, 32'h0, 4, 32'h0000005A, 1};
        vecs[2] = '{72'h41_00_00_00_00_00_00_00_00, 1, 0, 32'h0, 32'h0, 1, 32'h3F000000, 0};
        vecs[3] = '{72'h57_40_00_00_02_11_22_33_44, 9, 0, 32'h0, 32'h0, 1, 32'h3F000000, 1};
        vecs[4] = '{72'h52_20_00_00_04_00_00_00_00, 5, 1, 32'h20000004, 32'h0, 4, 32'hFEADBEEB, 1};
        vecs[5] = '{72'h57_12_34_56_78_DE_AD_BE_EF, 9, 2, 32'h12345678, 32'hDEADBEEF, 1, 32'h4B000000, 1};
        vecs[6] = '{72'h52_00_00_00_01_00_00_00_00, 5, 0, 32'h0, 32'h0, 1, 32'h3F000000, 1};

        ifc.rx_valid = 1'b0;
        ifc.rx_data  = 8'h00;
        ifc.tx_ready = 1'b1;
        reset = 1'b1;
        repeat (3) tick();
        check_reset_state("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) applyStimulus(i);

        $display("[TB] backpressure read");
        ifc.tx_ready = 1'b0;
        s0 = strobe_cnt;
        t0 = tx_q.size();
        bp_exp = 32'h0000005A;
        send_bytes(72'h52_40_00_00_10_00_00_00_00, 5, a);
        for (int j = 0; j < 4; j++) begin
            wait_tx_valid($sformatf("bp byte %0d", j));
            for (int h = 0; h < 5; h++) begin
                checkOutput($sformatf("bp hold %0d.%0d", j, h), {24'b0, ifc.tx_data}, {24'b0, bp_exp[31-8*j -: 8]});
                if (h == 1) begin
                    ifc.rx_valid = 1'b1;
                    ifc.rx_data  = 8'h41;
                end
                tick();
                ifc.rx_valid = 1'b0;
            end
            ifc.tx_ready = 1'b1;
            tick();
            ifc.tx_ready = 1'b0;
        end
        repeat (6) tick();
        checkOutput("bp strobes", strobe_cnt - s0, 1);
        checkOutput("bp tx count", tx_q.size() - t0, 4);
        for (int j = 0; j < 4 && t0 + j < tx_q.size(); j++)
            checkOutput($sformatf("bp sent byte %0d", j), {24'b0, tx_q[t0+j]}, {24'b0, bp_exp[31-8*j -: 8]});
        checkOutput("bp tx_data stable", stab_err, 0);
        checkOutput("bp busy after", {31'b0, busy}, 32'h0);

        $display("[TB] inter-byte timeout");
        ifc.tx_ready = 1'b1;
        s0 = strobe_cnt;
        t0 = tx_q.size();
        send_bytes(72'h52_40_00_00_00_00_00_00_00, 2, a);
        while (cyc < a + 15) tick();
        checkOutput("timeout busy before limit", {31'b0, busy}, 32'h1);
        tick();
        checkOutput("timeout busy at limit", {31'b0, busy}, 32'h0);
        repeat (4) tick();
        checkOutput("timeout strobes", strobe_cnt - s0, 0);
        checkOutput("timeout tx count", tx_q.size() - t0, 0);
        applyStimulus(1);

        $display("[TB] reset after three address bytes");
        s0 = strobe_cnt;
        t0 = tx_q.size();
        send_bytes(72'h57_40_00_00_00_00_00_00_00, 4, a);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        repeat (5) tick();
        checkOutput("midframe reset busy", {31'b0, busy}, 32'h0);
        checkOutput("midframe reset strobes", strobe_cnt - s0, 0);
        applyStimulus(0);
        checkOutput("midframe total strobes", strobe_cnt - s0, 1);
        checkOutput("midframe total tx", tx_q.size() - t0, 1);

        $display("[TB] reset during response");
        ifc.tx_ready = 1'b0;
        send_bytes(72'h52_40_00_00_10_00_00_00_00, 5, a);
        wait_tx_valid("midresp");
        s0 = strobe_cnt;
        t0 = tx_q.size();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ifc.tx_ready = 1'b1;
        repeat (10) tick();
        checkOutput("midresp tx count", tx_q.size() - t0, 0);
        checkOutput("midresp strobes", strobe_cnt - s0, 0);
        check_reset_state("midresp");
        checkOutput("rd and wr overlap", both_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
